// File: rtl/fma_pkg.sv
// Shared types and constants for the fmas issue/retire slice.
package fma_pkg;

   typedef enum logic [1:0] {
      FMADD  = 2'd0,
      FMSUB  = 2'd1,
      FNMSUB = 2'd2,
      FNMADD = 2'd3
   } fma_op_e;

   localparam int unsigned FMA_LATENCY = 2;
   localparam int unsigned FMA_TAG_W   = 4;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   typedef struct packed {
      fma_op_e              op;
      logic [FMA_TAG_W-1:0] tag;
      logic [31:0]          x;
      logic [31:0]          y;
      logic [31:0]          z;
   } fma_req_t;

   typedef struct packed {
      logic [FMA_TAG_W-1:0] tag;
      logic [31:0]          rslt;
      logic [4:0]           flag;
   } fma_rsp_t;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/fma_issue_ctrl_if.sv
// Upstream operation and downstream result handshakes of fma_issue_ctrl.
interface fma_issue_ctrl_if #(
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      in_x;
   logic [31:0]      in_y;
   logic [31:0]      in_z;
   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic [31:0]      out_rslt;
   logic [4:0]       out_flag;

   modport master (
      output in_valid, in_op, in_tag, in_x, in_y, in_z, out_ready,
      input  in_ready, out_valid, out_tag, out_rslt, out_flag
   );

   modport slave (
      input  in_valid, in_op, in_tag, in_x, in_y, in_z, out_ready,
      output in_ready, out_valid, out_tag, out_rslt, out_flag
   );
endinterface

// File: rtl/fma_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module fma_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   output logic                       full,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is data-only; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/fma_issue_ctrl.sv
// Credit-gated issue/retire front end for the fixed-latency, non-stalling fmas unit.
// Sticky flag accumulator is built only when FMA_ISSUE_FFLAGS_EN is defined.
module fma_issue_ctrl
   import fma_pkg::*;
#(
   parameter int unsigned IQ_DEPTH = 2,
   parameter int unsigned RQ_DEPTH = 4,
   parameter int unsigned TAG_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   fma_issue_ctrl_if.slave     bus,
   output logic                req,
   output logic [31:0]         req_command,
   output logic [31:0]         x,
   output logic [31:0]         y,
   output logic [31:0]         z,
   input  logic [31:0]         rslt,
   input  logic [4:0]          flag,
   output logic [4:0]          fflags,
   input  logic                fflags_clr
);

   typedef struct packed {
      fma_op_e          op;
      logic [TAG_W-1:0] tag;
      logic [31:0]      x;
      logic [31:0]      y;
      logic [31:0]      z;
   } iq_entry_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      rslt;
      logic [4:0]       flag;
   } rq_entry_t;

   localparam int unsigned RQ_CW = $clog2(RQ_DEPTH + 1);

   iq_entry_t                      iq_wdata, iq_head;
   logic                           iq_full, iq_empty, iq_push;
   logic [$clog2(IQ_DEPTH+1)-1:0]  unused_iq_count;
   rq_entry_t                      rq_wdata, rq_head;
   logic                           rq_full, rq_empty, rq_push, rq_pop;
   logic [RQ_CW-1:0]               rq_count;
   logic [FMA_LATENCY-1:0]         pipe_v_q;
   logic [TAG_W-1:0]               pipe_tag_q [FMA_LATENCY];
   int unsigned                    credit_used;
   logic                           flip_x, flip_z;

   assign bus.in_ready = ~iq_full;
   assign iq_push      = bus.in_valid & ~iq_full;
   assign iq_wdata     = '{op: fma_op_e'(bus.in_op), tag: bus.in_tag,
                           x: bus.in_x, y: bus.in_y, z: bus.in_z};

   fma_sync_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(IQ_DEPTH)) u_iq (
      .clk   (clk),
      .reset (reset),
      .push  (iq_push),
      .wdata (iq_wdata),
      .full  (iq_full),
      .pop   (req),
      .rdata (iq_head),
      .empty (iq_empty),
      .count (unused_iq_count)
   );

   // Every in-flight op already owns a result slot, so capture can never overflow.
   always_comb begin
      credit_used = 32'(rq_count);
      for (int i = 0; i < FMA_LATENCY; i++) credit_used += 32'(pipe_v_q[i]);
   end

   assign req         = ~iq_empty & (credit_used < RQ_DEPTH);
   assign req_command = {30'b0, iq_head.op};

   always_comb begin
      flip_x = (iq_head.op == FNMSUB) || (iq_head.op == FNMADD);
      flip_z = (iq_head.op == FMSUB)  || (iq_head.op == FNMADD);
      x = {iq_head.x[31] ^ (flip_x & ~is_nan(iq_head.x)), iq_head.x[30:0]};
      y = iq_head.y;
      z = {iq_head.z[31] ^ (flip_z & ~is_nan(iq_head.z)), iq_head.z[30:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) pipe_v_q <= '0;
      else       pipe_v_q <= {pipe_v_q[FMA_LATENCY-2:0], req};
      pipe_tag_q[0] <= iq_head.tag;
      for (int i = 1; i < FMA_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
   end

   assign rq_push  = pipe_v_q[FMA_LATENCY-1];
   assign rq_wdata = '{tag: pipe_tag_q[FMA_LATENCY-1], rslt: rslt, flag: flag};
   assign rq_pop   = bus.out_valid & bus.out_ready;

   fma_sync_fifo #(.WIDTH($bits(rq_entry_t)), .DEPTH(RQ_DEPTH)) u_rq (
      .clk   (clk),
      .reset (reset),
      .push  (rq_push),
      .wdata (rq_wdata),
      .full  (rq_full),
      .pop   (rq_pop),
      .rdata (rq_head),
      .empty (rq_empty),
      .count (rq_count)
   );

   assign bus.out_valid = ~rq_empty;
   assign bus.out_tag   = rq_head.tag;
   assign bus.out_rslt  = rq_head.rslt;
   assign bus.out_flag  = rq_head.flag;

   capture_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(rq_push && rq_full));

`ifdef FMA_ISSUE_FFLAGS_EN
   logic [4:0] fflags_q;

   // A retiring result lands on top of a coincident clear.
   always_ff @(posedge clk) begin
      if (reset)           fflags_q <= '0;
      else if (rq_pop)     fflags_q <= (fflags_clr ? 5'h0 : fflags_q) | rq_head.flag;
      else if (fflags_clr) fflags_q <= '0;
   end

   assign fflags = fflags_q;
`else
   logic unused_fflags_clr;

   assign unused_fflags_clr = fflags_clr;
   assign fflags            = 5'h0;
`endif

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed bench for fma_issue_ctrl with a two-cycle fmas stand-in.
// Expected fflags follow FMA_ISSUE_FFLAGS_EN.
module tb_fma_issue_ctrl;
   import fma_pkg::*;

`ifdef FMA_ISSUE_FFLAGS_EN
   localparam bit FfEn = 1'b1;
`else
   localparam bit FfEn = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req;
   logic [31:0] req_command, x, y, z;
   logic [31:0] rslt;
   logic [4:0]  flag;
   logic [4:0]  fflags;
   logic        fflags_clr;
   int          checks;
   int          errors;

   fma_issue_ctrl_if #(.TAG_W(4)) bus ();

   fma_issue_ctrl #(.IQ_DEPTH(2), .RQ_DEPTH(4), .TAG_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .req         (req),
      .req_command (req_command),
      .x           (x),
      .y           (y),
      .z           (z),
      .rslt        (rslt),
      .flag        (flag),
      .fflags      (fflags),
      .fflags_clr  (fflags_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fmas stand-in: knows the directed vectors, otherwise returns x^z with NX.
   function automatic logic [36:0] fmas_eval(input logic [31:0] a, b, c);
      if (a == 32'h7f800000 && b == 32'h0) return {32'hffc00000, 5'h10};
      if (b == 32'h40000000 && a[30:0] == 31'h3f800000 && c[30:0] == 31'h40400000) begin
         case ({a[31], c[31]})
            2'b00:   return {32'h40a00000, 5'h00};
            2'b01:   return {32'hbf800000, 5'h00};
            2'b10:   return {32'h3f800000, 5'h00};
            default: return {32'hc0a00000, 5'h00};
         endcase
      end
      return {a ^ c, 5'h01};
   endfunction

   logic [36:0] m_s1, m_s2;
   always @(posedge clk) begin
      m_s1 <= fmas_eval(x, y, z);
      m_s2 <= m_s1;
   end
   assign {rslt, flag} = m_s2;

   initial begin
      #400000;
      $display("FAIL watchdog: no finish after 400000 time units");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input fma_req_t r);
      bus.in_valid = v;
      bus.in_op    = r.op;
      bus.in_tag   = r.tag;
      bus.in_x     = r.x;
      bus.in_y     = r.y;
      bus.in_z     = r.z;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      fflags_clr = 1'b0;
      bus.out_ready = 1'b0;
      drive_in(1'b0, '0);
      repeat (3) tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      checks++;
      if (fflags !== 5'h0) begin errors++; $display("FAIL reset_fflags: got %h want 0", fflags); end
   endtask

   task automatic run_op(input string name, input fma_req_t v, input logic [31:0] exp_x,
                         input logic [31:0] exp_z, input logic [31:0] exp_r,
                         input logic [4:0] exp_f, input logic clr_at_pop,
                         input logic [4:0] exp_ff);
      bus.out_ready = 1'b1;
      drive_in(1'b1, v);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready);
      end
      tick();
      drive_in(1'b0, v);
      #1;
      checks++;
      if (req !== 1'b1) begin errors++; $display("FAIL %s req: got %b want 1", name, req); end
      checks++;
      if (req_command !== {30'b0, v.op}) begin
         errors++; $display("FAIL %s req_command: got %h want %h", name, req_command, v.op);
      end
      checks++;
      if ({x, y, z} !== {exp_x, v.y, exp_z}) begin
         errors++;
         $display("FAIL %s operands: got %h %h %h want %h %h %h", name, x, y, z, exp_x, v.y, exp_z);
      end
      tick();
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL %s early_out_valid: got %b want 0", name, bus.out_valid);
      end
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL %s out_valid: got %b want 1", name, bus.out_valid);
      end
      checks++;
      if ({bus.out_tag, bus.out_rslt, bus.out_flag} !== {v.tag, exp_r, exp_f}) begin
         errors++;
         $display("FAIL %s result: got tag %h rslt %h flag %h want tag %h rslt %h flag %h", name,
                  bus.out_tag, bus.out_rslt, bus.out_flag, v.tag, exp_r, exp_f);
      end
      fflags_clr = clr_at_pop;
      tick();
      fflags_clr = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL %s out_valid_after_pop: got %b want 0", name, bus.out_valid);
      end
      checks++;
      if (fflags !== exp_ff) begin
         errors++; $display("FAIL %s fflags: got %h want %h", name, fflags, exp_ff);
      end
   endtask

   task automatic test_sign_adjust();
      logic [4:0] nx;
      nx = FfEn ? 5'h01 : 5'h00;
      run_op("fmadd", '{FMADD, 4'd5, 32'h3f800000, 32'h40000000, 32'h40400000},
             32'h3f800000, 32'h40400000, 32'h40a00000, 5'h00, 1'b0, 5'h00);
      run_op("fmsub", '{FMSUB, 4'd6, 32'h3f800000, 32'h40000000, 32'h40400000},
             32'h3f800000, 32'hc0400000, 32'hbf800000, 5'h00, 1'b0, 5'h00);
      run_op("fnmsub", '{FNMSUB, 4'd7, 32'h3f800000, 32'h40000000, 32'h40400000},
             32'hbf800000, 32'h40400000, 32'h3f800000, 5'h00, 1'b0, 5'h00);
      run_op("fnmadd", '{FNMADD, 4'd8, 32'h3f800000, 32'h40000000, 32'h40400000},
             32'hbf800000, 32'hc0400000, 32'hc0a00000, 5'h00, 1'b0, 5'h00);
      // NaN x keeps its sign; z still flips.
      run_op("nan_keep", '{FNMADD, 4'd9, 32'h7fc00001, 32'h40000000, 32'h40400000},
             32'h7fc00001, 32'hc0400000, 32'hbf800001, 5'h01, 1'b0, nx);
   endtask

   task automatic test_fflags();
      logic [4:0] nv;
      nv = FfEn ? 5'h10 : 5'h00;
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      #1;
      checks++;
      if (fflags !== 5'h0) begin errors++; $display("FAIL ff_clear: got %h want 0", fflags); end
      run_op("inf_zero", '{FMADD, 4'd1, 32'h7f800000, 32'h0, 32'h0},
             32'h7f800000, 32'h0, 32'hffc00000, 5'h10, 1'b0, nv);
      repeat (3) tick();
      #1;
      checks++;
      if (fflags !== nv) begin errors++; $display("FAIL ff_hold: got %h want %h", fflags, nv); end
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      #1;
      checks++;
      if (fflags !== 5'h0) begin errors++; $display("FAIL ff_clear2: got %h want 0", fflags); end
      run_op("inf_zero2", '{FMADD, 4'd2, 32'h7f800000, 32'h0, 32'h0},
             32'h7f800000, 32'h0, 32'hffc00000, 5'h10, 1'b0, nv);
      run_op("clr_with_pop", '{FMADD, 4'd3, 32'h1, 32'h0, 32'h0},
             32'h1, 32'h0, 32'h1, 5'h01, 1'b1, FfEn ? 5'h01 : 5'h00);
   endtask

   task automatic test_back_to_back();
      int next, reqs, ret;
      fma_req_t r;
      next = 0;
      reqs = 0;
      ret  = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         r = '{FMADD, 4'(next), 32'h10000000 | 32'(next), 32'h0, 32'h100};
         drive_in(next < 8, r);
         #1;
         if (req) reqs++;
         if (bus.in_valid && bus.in_ready) next++;
         tick();
      end
      checks++;
      if (reqs != 4) begin errors++; $display("FAIL stall_reqs: got %0d want 4", reqs); end
      checks++;
      if (next != 6) begin errors++; $display("FAIL stall_pushes: got %0d want 6", next); end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready);
      end
      bus.out_ready = 1'b1;
      for (int j = 0; j < 60 && ret < 8; j++) begin
         r = '{FMADD, 4'(next), 32'h10000000 | 32'(next), 32'h0, 32'h100};
         drive_in(next < 8, r);
         #1;
         // Slot freed by this pop is credited only from the next cycle.
         if (j == 0) begin
            checks++;
            if (req !== 1'b0) begin errors++; $display("FAIL pop_cycle_req: got %b want 0", req); end
         end
         if (j == 1) begin
            checks++;
            if (req !== 1'b1) begin errors++; $display("FAIL after_pop_req: got %b want 1", req); end
         end
         if (bus.in_valid && bus.in_ready) next++;
         if (bus.out_valid) begin
            checks++;
            if ({bus.out_tag, bus.out_rslt} !== {4'(ret), (32'h10000000 | 32'(ret)) ^ 32'h100})
            begin
               errors++;
               $display("FAIL retire_%0d: got tag %h rslt %h want tag %h rslt %h", ret,
                        bus.out_tag, bus.out_rslt, 4'(ret), (32'h10000000 | 32'(ret)) ^ 32'h100);
            end
            ret++;
         end
         tick();
      end
      drive_in(1'b0, '0);
      checks++;
      if (ret != 8) begin errors++; $display("FAIL retire_count: got %0d want 8", ret); end
   endtask

   task automatic test_reset_inflight();
      int seen;
      seen = 0;
      bus.out_ready = 1'b1;
      drive_in(1'b1, '{FMADD, 4'd9, 32'h3f800000, 32'h40000000, 32'h40400000});
      tick();
      drive_in(1'b0, '0);
      #1;
      checks++;
      if (req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", req); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
      end
      checks++;
      if (fflags !== 5'h0) begin errors++; $display("FAIL rst_fflags: got %h want 0", fflags); end
      for (int c = 0; c < 8; c++) begin
         if (bus.out_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rst_discard: got %0d results want 0", seen); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sign_adjust();
      test_fflags();
      test_back_to_back();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fma_issue_ctrl.md
# fma_issue_ctrl

Issue/retire controller that sits directly in front of `fmas`. It accepts tagged single-precision FMA-family operations over a valid/ready handshake and applies operand sign negation for the subtract and negate variants. It drives `fmas` with `req`/`x`/`y`/`z` only when result space is guaranteed, because `fmas` has a fixed latency and cannot stall. It captures `rslt`/`flag` two cycles later into a result FIFO and presents them downstream with their tag.

## Interface
Parameters:
- `IQ_DEPTH`, default 2: input queue entries, power of two, ≥2.
- `RQ_DEPTH`, default 4: result queue entries, power of two, ≥4.
- `TAG_W`, default 4: width of the operation tag.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream operation valid.
- `in_ready` out 1: upstream may push.
- `in_op` in 2: operation select; 0 FMADD, 1 FMSUB, 2 FNMSUB, 3 FNMADD.
- `in_tag` in TAG_W: opaque tag, returned with the result.
- `in_x`, `in_y`, `in_z` in 32 each: IEEE-754 binary32 operands.
- `req` out 1: issue strobe to `fmas`.
- `req_command` out 32 (integer): `{30'b0, op}` of the issued entry.
- `x`, `y`, `z` out 32 each: sign-adjusted operands to `fmas`.
- `rslt` in 32: result from `fmas`.
- `flag` in 5: exception flags from `fmas`, ordered {NV, DZ, OF, UF, NX}.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts.
- `out_tag` out TAG_W: tag of the result.
- `out_rslt` out 32: result value.
- `out_flag` out 5: result flags.
- `fflags` out 5: sticky OR of retired flags.
- `fflags_clr` in 1: clears `fflags`.

## Operation
- Input queue: synchronous FIFO of {op, tag, x, y, z}.
  - `in_ready` = not full. A push occurs when `in_valid & in_ready`.
  - A pop while full does not assert `in_ready` in the same cycle.
- Sign adjust on the head entry, combinational:
  - FMSUB flips z[31].
  - FNMSUB flips x[31].
  - FNMADD flips x[31] and z[31].
  - A NaN operand (exp==8'hff, frac!=0) is never flipped.
- Issue condition: `req` = head valid & (rq_count + inflight < RQ_DEPTH). When `req` is high the head pops in the same cycle.
- In-flight tracking: a 2-stage shift register of {valid, tag}, advanced every cycle. Stage 0 loads {`req`, head tag}. `inflight` = number of valid stages.
- Capture: when stage 1 is valid, push {tag, `rslt`, `flag`} into the result queue. The credit check guarantees this push never meets a full queue; assert this in simulation.
- Output: the result queue head drives `out_*`. A pop occurs on `out_valid & out_ready`.
  - A slot freed by a pop is credited from the next cycle, since rq_count is registered.
  - A simultaneous push and pop keeps the count unchanged.
- fflags: `fflags |= out_flag` on each pop; `fflags_clr` zeroes it. When clear and pop coincide, the result is `out_flag` (the pop wins over the prior value).
- Ordering: strictly in order; no reordering anywhere.
- Reset:
  - Clears both queues, the in-flight pipe and `fflags`.
  - A result returning from `fmas` after reset is discarded, because its stage is invalid.
  - Output reset values: `in_ready`=1 (the cycle after reset falls), `req`=0, `out_valid`=0, `fflags`=0. `out_*` data and `x`/`y`/`z` are don't-care while not valid.

## Timing
- Cycle T: push accepted.
- T+1: earliest `req`, since the head is registered.
- T+3: `rslt` sampled, because `fmas` result is valid 2 cycles after `req`.
- T+4: `out_valid`. Minimum latency is 4 cycles.
- Throughput: one op per cycle while credits allow.
- With `out_ready` held low, at most RQ_DEPTH ops are issued. After that `in_ready` falls once the input queue fills.

## Configuration
- `FMA_ISSUE_FFLAGS_EN` defined: sticky accumulator implemented as described.
- Undefined:
  - `fflags` is tied to 5'h0 and `fflags_clr` is ignored.
  - No flag register is inferred.
  - `out_flag` is still delivered per result.

## Structure
- Shared package `fma_pkg`:
  - `fma_op_e` enum (FMADD/FMSUB/FNMSUB/FNMADD).
  - `FMA_LATENCY`=2.
  - Flag bit index constants (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - Packed structs `fma_req_t` {op, tag, x, y, z} and `fma_rsp_t` {tag, rslt, flag}.
- Sub-module `fma_sync_fifo` (parameterised width/depth, count output) is instantiated twice: once as the input queue and once as the result queue.

## Test plan
- FMADD x=3f800000 y=40000000 z=40400000, tag 5, `out_ready`=1 → at T+4 `out_rslt`=40a00000, `out_flag`=0, `out_tag`=5.
- Same operands with FMSUB → bf800000. FNMSUB → 3f800000. FNMADD → c0a00000. `req_command`=1/2/3 seen at issue.
- x=7f800000 y=00000000 z=0, FMADD → ffc00000, `out_flag`=5'h10. `fflags`=5'h10 after pop and holds until `fflags_clr`.
- `out_ready`=0 and 8 back-to-back pushes:
  - exactly 4 `req` pulses, then `in_ready` low after the input queue fills;
  - release `out_ready` → all 8 tags retire in order 0..7, none lost.
- Pop and issue with a full result queue in the same cycle → the next `req` occurs no earlier than the following cycle, and the in-flight capture never overflows.
- Assert `reset` one cycle after `req` → no `out_valid` afterwards, `fflags`=0, `in_ready`=1 after reset deasserts.
